// File: rtl/pet_dma_loader.sv
// rtl/pet_dma_loader.sv - HPS ioctl download sequencer onto the pet2001hw DMA write port
//
// Purpose: turns ioctl byte streams (PRG files or raw RAM/ROM images) into paced
// single-cycle DMA writes. It back-pressures the HPS with ioctl_wait and patches the
// BASIC end-of-program pointer after a PRG. The CPU is held while a load is in flight.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   ioctl_download/index/wr/addr/dout  HPS download stream (inputs)
//   ioctl_wait                     back-pressure; strobes are ignored while high
//   dma_addr/dma_din/dma_we        DMA write port (registered)
//   cpu_hold                       CPU stall request
//   load_end                       first free byte after the last PRG
//   load_err                       sticky PRG error (short file or RAM overflow)
module pet_dma_loader #(
  parameter logic [7:0]  PRG_INDEX = 8'h41,
  parameter logic [7:0]  IMG_INDEX = 8'h00,
  parameter logic [15:0] RAM_TOP   = 16'h8000,
  parameter logic [15:0] IMG_LO    = 16'h0400,
  parameter logic [15:0] IMG_OFS   = 16'h8000,
  parameter logic [15:0] PTR_ADDR  = 16'h002A,
  parameter int          WR_GAP    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_din,
  output logic        dma_we,
  output logic        cpu_hold,
  output logic [15:0] load_end,
  output logic        load_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRG_HDR0, S_PRG_HDR1, S_PRG_DATA, S_IMG_DATA, S_PATCH_LO, S_PATCH_HI
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ptr_q, ptr_d;
  logic [3:0]  gap_q, gap_d;
  logic        wait_q, wait_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  din_q, din_d;
  logic        hold_q, hold_d;
  logic [15:0] load_end_q, load_end_d;
  logic        load_err_q, load_err_d;

  logic        accept;
  logic [15:0] img_ofs;
  logic        img_in_range;

  // Raw images only ever address the low 64 KiB of the file.
  logic unused_addr_hi;
  assign unused_addr_hi = ^ioctl_addr[24:16];

  assign accept       = ioctl_wr && !wait_q;
  assign img_ofs      = ioctl_addr[15:0];
  assign img_in_range = (img_ofs >= IMG_LO) && (img_ofs < RAM_TOP);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    addr_d     = addr_q;
    din_d      = din_q;
    load_end_d = load_end_q;
    load_err_d = load_err_q;
    we_d       = 1'b0;
    // wait covers the write cycle itself plus WR_GAP idle cycles; gap_q counts
    // the idle cycles still owed after the current one.
    wait_d     = (gap_q != 4'd0);
    gap_d      = (gap_q != 4'd0) ? gap_q - 4'd1 : 4'd0;
    hold_d     = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (ioctl_download) begin
          if (ioctl_index == PRG_INDEX) begin
            state_d    = S_PRG_HDR0;
            load_err_d = 1'b0;
          end else if (ioctl_index == IMG_INDEX) begin
            state_d = S_IMG_DATA;
          end
        end
      end
      S_PRG_HDR0: begin
        if (!ioctl_download) begin
          load_err_d = 1'b1;
          state_d    = S_IDLE;
        end else if (accept) begin
          ptr_d[7:0] = ioctl_dout;
          state_d    = S_PRG_HDR1;
        end
      end
      S_PRG_HDR1: begin
        if (!ioctl_download) begin
          load_err_d = 1'b1;
          state_d    = S_IDLE;
        end else if (accept) begin
          ptr_d[15:8] = ioctl_dout;
          state_d     = S_PRG_DATA;
        end
      end
      S_PRG_DATA: begin
        if (!ioctl_download) begin
          if (!wait_q) begin
            we_d       = 1'b1;
            wait_d     = 1'b1;
            gap_d      = 4'(WR_GAP);
            addr_d     = PTR_ADDR;
            din_d      = ptr_q[7:0];
            load_end_d = ptr_q;
            state_d    = S_PATCH_LO;
          end
        end else if (accept) begin
          if (ptr_q < RAM_TOP) begin
            we_d   = 1'b1;
            wait_d = 1'b1;
            gap_d  = 4'(WR_GAP);
            addr_d = ptr_q;
            din_d  = ioctl_dout;
            ptr_d  = ptr_q + 16'd1;
          end else begin
            load_err_d = 1'b1;
          end
        end
      end
      S_IMG_DATA: begin
        if (!ioctl_download) begin
          if (!wait_q) state_d = S_IDLE;
        end else if (accept && img_in_range) begin
          we_d   = 1'b1;
          wait_d = 1'b1;
          gap_d  = 4'(WR_GAP);
          addr_d = img_ofs + IMG_OFS;
          din_d  = ioctl_dout;
        end
      end
      S_PATCH_LO: begin
        if (!wait_q) begin
          we_d    = 1'b1;
          wait_d  = 1'b1;
          gap_d   = 4'(WR_GAP);
          addr_d  = PTR_ADDR + 16'd1;
          din_d   = ptr_q[15:8];
          state_d = S_PATCH_HI;
        end
      end
      S_PATCH_HI: begin
        if (!wait_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= 16'd0;
      gap_q      <= 4'd0;
      wait_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 16'd0;
      din_q      <= 8'd0;
      hold_q     <= 1'b0;
      load_end_q <= 16'd0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gap_q      <= gap_d;
      wait_q     <= wait_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      hold_q     <= hold_d;
      load_end_q <= load_end_d;
      load_err_q <= load_err_d;
    end
  end

  assign ioctl_wait = wait_q;
  assign dma_we     = we_q;
  assign dma_addr   = addr_q;
  assign dma_din    = din_q;
  assign cpu_hold   = hold_q;
  assign load_end   = load_end_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_pet_dma_loader.sv
// tb/tb_pet_dma_loader.sv - scoreboard bench for pet_dma_loader
module tb_pet_dma_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [15:0] dma_addr;
  logic [7:0]  dma_din;
  logic        dma_we;
  logic        cpu_hold;
  logic [15:0] load_end;
  logic        load_err;

  always #5 clk = ~clk;

  pet_dma_loader dut (
    .clk(clk), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait),
    .dma_addr(dma_addr), .dma_din(dma_din), .dma_we(dma_we),
    .cpu_hold(cpu_hold), .load_end(load_end), .load_err(load_err)
  );

  typedef struct packed {logic [15:0] a; logic [7:0] d;} wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  fdata[$];
  logic [24:0] foffs[$];
  logic [15:0] m_end = 16'h0000;
  logic        m_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every DMA strobe must match the next expected write.
  always @(negedge clk) begin
    if (!reset && dma_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_dma_we: got addr %h data %h expected no write", dma_addr, dma_din);
      end else begin
        mon_e = exp_q.pop_front();
        chk("dma_write", {8'h00, dma_addr, dma_din}, {8'h00, mon_e.a, mon_e.d});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ioctl_wait && n < 64) begin
      tick();
      n++;
    end
    if (ioctl_wait) chk("wait_timeout", 32'(ioctl_wait), 32'd0);
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    wait_ready();
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
  endtask

  // Reference: what a loader must write for the file in fdata/foffs.
  task automatic model_file(input logic [7:0] idx);
    int ptr;
    if (idx == 8'h41) begin
      m_err = 1'b0;
      if (fdata.size() < 2) begin
        m_err = 1'b1;
      end else begin
        ptr = {fdata[1], fdata[0]};
        for (int i = 2; i < fdata.size(); i++) begin
          if (ptr < 'h8000) begin
            exp_q.push_back({16'(ptr), fdata[i]});
            ptr++;
          end else begin
            m_err = 1'b1;
          end
        end
        exp_q.push_back({16'h002A, 8'(ptr)});
        exp_q.push_back({16'h002B, 8'(ptr >> 8)});
        m_end = 16'(ptr);
      end
    end else if (idx == 8'h00) begin
      for (int i = 0; i < fdata.size(); i++) begin
        if (foffs[i][15:0] >= 16'h0400 && foffs[i][15:0] < 16'h8000)
          exp_q.push_back({16'(foffs[i][15:0] + 16'h8000), fdata[i]});
      end
    end
  endtask

  task automatic end_file(input string tag);
    int n = 0;
    ioctl_download = 1'b0;
    while (cpu_hold && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_hold_released"}, 32'(cpu_hold), 32'd0);
    repeat (3) tick();
    chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_load_end"}, 32'(load_end), 32'(m_end));
    chk({tag, "_load_err"}, 32'(load_err), 32'(m_err));
    chk({tag, "_hold_idle"}, 32'(cpu_hold), 32'd0);
    exp_q.delete();
  endtask

  task automatic run_file(input logic [7:0] idx, input string tag);
    model_file(idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
    tick();
    // Index changes mid-download must not matter for an accepted type.
    if (idx == 8'h41 || idx == 8'h00) ioctl_index = 8'($urandom);
    for (int i = 0; i < fdata.size(); i++) send_byte(foffs[i], fdata[i]);
    end_file(tag);
  endtask

  task automatic set_prg(input logic [7:0] b[$]);
    fdata = b;
    foffs.delete();
    for (int i = 0; i < b.size(); i++) foffs.push_back(25'(i));
  endtask

  initial begin
    logic [15:0] base;
    int len, r;
    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index = 8'h00;
    ioctl_wr = 1'b0;
    ioctl_addr = 25'd0;
    ioctl_dout = 8'd0;
    repeat (3) tick();
    chk("rst_dma_we", 32'(dma_we), 32'd0);
    chk("rst_wait", 32'(ioctl_wait), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd0);
    chk("rst_addr_din", {8'h00, dma_addr, dma_din}, 32'd0);
    chk("rst_load", {15'd0, load_err, load_end}, 32'd0);
    reset = 1'b0;
    tick();

    // Basic PRG.
    set_prg('{8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC});
    run_file(8'h41, "prg_basic");
    chk("prg_basic_end_const", 32'(load_end), 32'h0404);

    // Accept-to-strobe latency, wait window, and ignored strobe under wait.
    exp_q.push_back({16'h1000, 8'h5A});
    exp_q.push_back({16'h002A, 8'h01});
    exp_q.push_back({16'h002B, 8'h10});
    m_err = 1'b0;
    m_end = 16'h1001;
    ioctl_index = 8'h41;
    ioctl_download = 1'b1;
    tick();
    tick();
    send_byte(25'd0, 8'h00);
    send_byte(25'd1, 8'h10);
    wait_ready();
    ioctl_addr = 25'd2; ioctl_dout = 8'h5A; ioctl_wr = 1'b1;
    tick();
    chk("t_we_n1", 32'(dma_we), 32'd1);
    chk("t_wait_n1", 32'(ioctl_wait), 32'd1);
    ioctl_wr = 1'b0;
    tick();
    chk("t_wait_n2", 32'(ioctl_wait), 32'd1);
    chk("t_we_n2", 32'(dma_we), 32'd0);
    ioctl_addr = 25'd3; ioctl_dout = 8'hEE; ioctl_wr = 1'b1;
    tick();
    chk("t_wait_n3", 32'(ioctl_wait), 32'd1);
    ioctl_wr = 1'b0;
    tick();
    chk("t_wait_n4", 32'(ioctl_wait), 32'd0);
    chk("t_we_n4", 32'(dma_we), 32'd0);
    end_file("timing");

    // Overflow at RAM top.
    set_prg('{8'hFE, 8'h7F, 8'h11, 8'h22, 8'h33, 8'h44});
    run_file(8'h41, "prg_ovf");
    chk("prg_ovf_err_const", 32'(load_err), 32'd1);
    chk("prg_ovf_end_const", 32'(load_end), 32'h8000);

    // Raw image window edges.
    fdata = '{8'h01, 8'h02, 8'h03, 8'h04};
    foffs = '{25'h03FF, 25'h0400, 25'h7FFF, 25'h8000};
    run_file(8'h00, "img_edges");

    // Short PRG.
    set_prg('{8'h07});
    run_file(8'h41, "prg_short");
    chk("prg_short_err_const", 32'(load_err), 32'd1);

    // Randomised files.
    for (int f = 0; f < 12; f++) begin
      r = $urandom_range(0, 4);
      fdata.delete();
      foffs.delete();
      if (r <= 1) begin
        len = $urandom_range(0, 12);
        case ($urandom_range(0, 3))
          0: base = 16'($urandom_range('h7FF6, 'h7FFF));
          1: base = 16'($urandom_range('hFFF0, 'hFFFF));
          default: base = 16'($urandom_range('h0400, 'h7000));
        endcase
        for (int i = 0; i < len; i++) begin
          if (i == 0) fdata.push_back(base[7:0]);
          else if (i == 1) fdata.push_back(base[15:8]);
          else fdata.push_back(8'($urandom));
          foffs.push_back(25'(i));
        end
        run_file(8'h41, "rnd_prg");
      end else begin
        len = $urandom_range(1, 10);
        for (int i = 0; i < len; i++) begin
          fdata.push_back(8'($urandom));
          case ($urandom_range(0, 5))
            0: foffs.push_back(25'h03FF);
            1: foffs.push_back(25'h0400);
            2: foffs.push_back(25'h7FFF);
            3: foffs.push_back(25'h8000);
            4: foffs.push_back(25'($urandom_range(0, 'h1FFFFF)));
            default: foffs.push_back(25'($urandom_range('h0400, 'h7FFF)));
          endcase
        end
        run_file((r == 4) ? 8'h55 : 8'h00, (r == 4) ? "rnd_bad_idx" : "rnd_img");
      end
    end

    // Reset in the middle of a PRG: no patch may follow.
    set_prg('{8'h00, 8'h20, 8'h91, 8'h92, 8'h93});
    model_file(8'h41);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    ioctl_index = 8'h41;
    ioctl_download = 1'b1;
    tick();
    tick();
    for (int i = 0; i < fdata.size(); i++) send_byte(foffs[i], fdata[i]);
    wait_ready();
    tick();
    chk("rstmid_pending", 32'(exp_q.size()), 32'd0);
    chk("rstmid_hold_before", 32'(cpu_hold), 32'd1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    tick();
    chk("rstmid_we", 32'(dma_we), 32'd0);
    chk("rstmid_wait", 32'(ioctl_wait), 32'd0);
    chk("rstmid_hold", 32'(cpu_hold), 32'd0);
    reset = 1'b0;
    repeat (20) tick();
    chk("rstmid_hold_after", 32'(cpu_hold), 32'd0);
    chk("rstmid_load", {15'd0, load_err, load_end}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
